// File: rtl/pixel_stream_ctrl.sv
// -----------------------------------------------------------------------------
// pixel_stream_ctrl
// Raster pixel streamer. It fetches pixels from a combinational source
// addressed by PixAddr and presents them on a Valid/Ready stream. Frame marks
// pixel 0 of a frame and Line marks the last pixel of each line. With Ready
// held high the stream carries one pixel per clock, with no bubbles inside a
// frame or between continued frames.
//
// Parameters
//   COLS        pixels per line (1..256)
//   ROWS        lines per frame (1..256), COLS*ROWS <= 65536
//
// Ports
//   Clk         clock, rising edge
//   nReset      synchronous active-low reset
//   Start       begin a frame when idle
//   Continuous  sampled at the final pixel transfer; 1 = chain the next frame
//   Abort       drop the current frame and return to idle
//   PixAddr     raster index of the next pixel to fetch (col + row*COLS)
//   PixIn       pixel data for PixAddr, same cycle
//   Pixel       registered output pixel
//   Valid       Pixel/Frame/Line are valid
//   Ready       downstream accepts; transfer = Valid & Ready
//   Frame       first pixel of a frame
//   Line        last pixel of a line
//   Busy        streamer is running
//   Done        one-cycle pulse after the final pixel of a non-continued frame
//   FrameCnt    completed-frame counter (only with PIXEL_STREAM_FRAME_COUNT_EN)
//
// Build option
//   PIXEL_STREAM_FRAME_COUNT_EN  adds the 16-bit FrameCnt output
// -----------------------------------------------------------------------------
module pixel_stream_ctrl #(
    parameter int unsigned COLS = 10,
    parameter int unsigned ROWS = 10
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Start,
    input  logic        Continuous,
    input  logic        Abort,
    output logic [15:0] PixAddr,
    input  logic [7:0]  PixIn,
    output logic [7:0]  Pixel,
    output logic        Valid,
    input  logic        Ready,
    output logic        Frame,
    output logic        Line,
    output logic        Busy,
    output logic        Done
`ifdef PIXEL_STREAM_FRAME_COUNT_EN
    ,
    output logic [15:0] FrameCnt
`else
`endif
);

    localparam int unsigned COL_W  = 8;
    localparam int unsigned ROW_W  = 8;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned TOTAL  = COLS * ROWS;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TOTAL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          pixel_q, pixel_d;
    logic                valid_q, valid_d;
    logic                frame_q, frame_d;
    logic                line_q,  line_d;
    logic                last_q,  last_d;   // held pixel is the final one of the frame
    logic                done_q,  done_d;
    logic [COL_W-1:0]    col_q,   col_d;    // position of the next pixel to fetch
    logic [ROW_W-1:0]    row_q,   row_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic                load_c;            // capture PixIn and advance the fetch position

    // State register
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q <= IDLE;
            pixel_q <= 8'd0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            line_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pixel_q <= pixel_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
            line_q  <= line_d;
            last_q  <= last_d;
            done_q  <= done_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        pixel_d = pixel_q;
        valid_d = valid_q;
        frame_d = frame_q;
        line_d  = line_q;
        last_d  = last_q;
        done_d  = 1'b0;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        load_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start && !Abort) begin
                    load_c  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (Abort) begin
                    // Abort wins over a simultaneous transfer; held pixel is dropped
                    state_d = IDLE;
                    valid_d = 1'b0;
                    frame_d = 1'b0;
                    line_d  = 1'b0;
                    last_d  = 1'b0;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                end else if (valid_q && Ready) begin
                    if (!last_q || Continuous) begin
                        // Fetch position already wrapped to 0 after the final pixel
                        load_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        frame_d = 1'b0;
                        line_d  = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_c) begin
            pixel_d = PixIn;
            valid_d = 1'b1;
            frame_d = (addr_q == '0);
            line_d  = (col_q == COL_LAST);
            last_d  = (addr_q == ADDR_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
            addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 16'd1;
        end
    end

    assign PixAddr = addr_q;
    assign Pixel   = pixel_q;
    assign Valid   = valid_q;
    assign Frame   = frame_q;
    assign Line    = line_q;
    assign Busy    = (state_q == RUN);
    assign Done    = done_q;

`ifdef PIXEL_STREAM_FRAME_COUNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        final_xfer_c;

    // Final-pixel transfer that was not aborted
    assign final_xfer_c = (state_q == RUN) && !Abort && valid_q && Ready && last_q;

    always_comb begin
        cnt_d = cnt_q;
        if (final_xfer_c) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign FrameCnt = cnt_q;
`else
`endif

endmodule

// File: tb/tb_pixel_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pixel_stream_ctrl
// Directed bench for pixel_stream_ctrl: a 10x10 instance for the main stream
// behaviour and a 1x1 instance for the single-pixel frame corner case. Both
// share the control inputs; each has its own pixel source.
// -----------------------------------------------------------------------------
module tb_pixel_stream_ctrl;

    logic        clk;
    logic        nReset;
    logic        Start;
    logic        Continuous;
    logic        Abort;
    logic        Ready;

    logic [15:0] PixAddr;
    logic [7:0]  PixIn;
    logic [7:0]  Pixel;
    logic        Valid, Frame, Line, Busy, Done;

    logic [15:0] one_addr;
    logic [7:0]  one_pixin;
    logic [7:0]  one_pixel;
    logic        one_valid, one_frame, one_line, one_busy, one_done;

`ifdef PIXEL_STREAM_FRAME_COUNT_EN
    logic [15:0] FrameCnt;
    logic [15:0] one_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Pixel source: arbitrary, address-dependent pattern
    function automatic logic [7:0] pix_fn(input logic [15:0] a);
        return 8'(a * 16'd7 + 16'd3);
    endfunction

    assign PixIn     = pix_fn(PixAddr);
    assign one_pixin = pix_fn(one_addr) ^ 8'h5A;

    pixel_stream_ctrl #(.COLS(10), .ROWS(10)) u_dut (
        .Clk        (clk),
        .nReset     (nReset),
        .Start      (Start),
        .Continuous (Continuous),
        .Abort      (Abort),
        .PixAddr    (PixAddr),
        .PixIn      (PixIn),
        .Pixel      (Pixel),
        .Valid      (Valid),
        .Ready      (Ready),
        .Frame      (Frame),
        .Line       (Line),
        .Busy       (Busy),
        .Done       (Done)
`ifdef PIXEL_STREAM_FRAME_COUNT_EN
        ,
        .FrameCnt   (FrameCnt)
`endif
    );

    pixel_stream_ctrl #(.COLS(1), .ROWS(1)) u_one (
        .Clk        (clk),
        .nReset     (nReset),
        .Start      (Start),
        .Continuous (Continuous),
        .Abort      (Abort),
        .PixAddr    (one_addr),
        .PixIn      (one_pixin),
        .Pixel      (one_pixel),
        .Valid      (one_valid),
        .Ready      (Ready),
        .Frame      (one_frame),
        .Line       (one_line),
        .Busy       (one_busy),
        .Done       (one_done)
`ifdef PIXEL_STREAM_FRAME_COUNT_EN
        ,
        .FrameCnt   (one_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Main instance holding pixel k of a 10x10 frame
    task automatic chk_px(input string tag, input int k);
        chk({tag, "_valid"}, 32'(Valid), 32'd1);
        chk({tag, "_busy"},  32'(Busy), 32'd1);
        chk({tag, "_pixel"}, 32'(Pixel), 32'(pix_fn(16'(k))));
        chk({tag, "_frame"}, 32'(Frame), 32'(k == 0));
        chk({tag, "_line"},  32'(Line), 32'((k % 10) == 9));
        chk({tag, "_addr"},  32'(PixAddr), 32'((k + 1) % 100));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(Valid), 32'd0);
        chk({tag, "_busy"},  32'(Busy), 32'd0);
        chk({tag, "_frame"}, 32'(Frame), 32'd0);
        chk({tag, "_line"},  32'(Line), 32'd0);
        chk({tag, "_addr"},  32'(PixAddr), 32'd0);
    endtask

    initial begin
        int idx;
        int guard;
        logic r;

        nReset     = 1'b0;
        Start      = 1'b0;
        Continuous = 1'b0;
        Abort      = 1'b0;
        Ready      = 1'b1;
        tick();
        tick();

        // Reset state
        chk_idle("rst");
        chk("rst_pixel", 32'(Pixel), 32'd0);
        chk("rst_done",  32'(Done), 32'd0);
`ifdef PIXEL_STREAM_FRAME_COUNT_EN
        chk("rst_cnt", 32'(FrameCnt), 32'd0);
`endif

        // Start in the first cycle after reset release, single frame at Ready=1
        nReset = 1'b1;
        Start  = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            chk_px("f1", k);
            chk("f1_nodone", 32'(Done), 32'd0);
            tick();
        end
        chk("f1_done", 32'(Done), 32'd1);
        chk_idle("f1_end");
        tick();
        chk("f1_done_pulse", 32'(Done), 32'd0);
        chk("f1_busy_after", 32'(Busy), 32'd0);
`ifdef PIXEL_STREAM_FRAME_COUNT_EN
        chk("f1_cnt", 32'(FrameCnt), 32'd1);
`endif

        // Random Ready stalls: hold during stalls, exactly 100 transfers in order
        Start = 1'b1;
        tick();
        Start = 1'b0;
        idx   = 0;
        guard = 0;
        while (idx < 100 && guard < 3000) begin
            chk_px("stall", idx);
            chk("stall_nodone", 32'(Done), 32'd0);
            r     = 1'($urandom_range(0, 1));
            Ready = r;
            tick();
            if (r) idx++;
            guard++;
        end
        chk("stall_xfers", 32'(idx), 32'd100);
        chk("stall_done", 32'(Done), 32'd1);
        Ready = 1'b1;
        tick();

        // Continuous: three frames back to back, Start in RUN ignored
        nReset = 1'b0;
        tick();
        nReset     = 1'b1;
        Continuous = 1'b1;
        Start      = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            chk_px("cont", k % 100);
            chk("cont_nodone", 32'(Done), 32'd0);
            Start = (k == 150);
            if (k == 299) Continuous = 1'b0;
            tick();
        end
        Start = 1'b0;
        chk("cont_done", 32'(Done), 32'd1);
        chk_idle("cont_end");
`ifdef PIXEL_STREAM_FRAME_COUNT_EN
        chk("cont_cnt", 32'(FrameCnt), 32'd3);
`endif
        tick();

        // Abort at index 37 with Ready=1
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 37; k++) begin
            chk_px("ab", k);
            tick();
        end
        chk_px("ab_37", 37);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk_idle("ab_end");
        chk("ab_nodone", 32'(Done), 32'd0);
`ifdef PIXEL_STREAM_FRAME_COUNT_EN
        chk("ab_cnt", 32'(FrameCnt), 32'd3);
`endif
        tick();
        chk("ab_nodone2", 32'(Done), 32'd0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk_px("ab_restart", 0);

        // Reset mid-frame at index 50
        for (int k = 0; k < 50; k++) begin
            tick();
        end
        chk_px("mid_50", 50);
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        chk_idle("mid_rst");
        chk("mid_rst_pixel", 32'(Pixel), 32'd0);
        chk("mid_rst_done",  32'(Done), 32'd0);
`ifdef PIXEL_STREAM_FRAME_COUNT_EN
        chk("mid_rst_cnt", 32'(FrameCnt), 32'd0);
`endif

        // Start together with Abort in IDLE stays idle
        Start = 1'b1;
        Abort = 1'b1;
        tick();
        Start = 1'b0;
        Abort = 1'b0;
        chk_idle("sa");
        tick();
        chk_idle("sa2");

        // 1x1 frame: single transfer, then continuous
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        Start  = 1'b1;
        tick();
        Start = 1'b0;
        chk("one_valid", 32'(one_valid), 32'd1);
        chk("one_frame", 32'(one_frame), 32'd1);
        chk("one_line",  32'(one_line), 32'd1);
        chk("one_pixel", 32'(one_pixel), 32'(pix_fn(16'd0) ^ 8'h5A));
        chk("one_addr",  32'(one_addr), 32'd0);
        chk("one_busy",  32'(one_busy), 32'd1);
        tick();
        chk("one_done",  32'(one_done), 32'd1);
        chk("one_idle",  32'(one_valid), 32'd0);
        Continuous = 1'b1;
        Start      = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("one_c_valid", 32'(one_valid), 32'd1);
            chk("one_c_frame", 32'(one_frame), 32'd1);
            chk("one_c_line",  32'(one_line), 32'd1);
            chk("one_c_done",  32'(one_done), 32'd0);
            tick();
        end
        Continuous = 1'b0;
        tick();
        chk("one_c_end_done",  32'(one_done), 32'd1);
        chk("one_c_end_valid", 32'(one_valid), 32'd0);
`ifdef PIXEL_STREAM_FRAME_COUNT_EN
        chk("one_cnt", 32'(one_cnt), 32'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
